// File: rtl/sram_data_responder_pkg.sv
// Shared definitions for the SRAM data responder: FSM encoding and latency limits.
// Latency: n/a (package).
// Backpressure: n/a (package).
package sram_data_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int MAX_LATENCY = 15;

    // Counter preload on accept: WAIT lasts LATENCY-1 cycles, counting down to 0.
    function automatic logic [3:0] wait_preload(input int latency);
        return (latency >= 2) ? 4'(latency - 2) : 4'd0;
    endfunction

endpackage

// File: rtl/sram_data_responder_byte_we_ram.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read port.
// Latency: read data appears the cycle after rd_en_i; writes take effect at the same edge.
// Backpressure: none; one access per cycle, caller sequences requests.
module byte_we_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rd_en_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    // Storage array: byte lanes written independently, never reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Read register: only a read access updates it, so it holds across writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= 32'd0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_data_responder.sv
// Memory-side responder for the CPU data port: one outstanding request, internal word RAM.
// Latency: data_ok pulses LATENCY cycles after the accepting edge (LATENCY clamped to 1..15).
// Backpressure: addr_ok low while a request waits; accept allowed in IDLE and in RESP (back-to-back).
module sram_data_responder
    import sram_data_responder_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  sel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int LAT_C = (LATENCY < 1) ? 1 :
                           (LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY;
    localparam logic [3:0] CNT_INIT = wait_preload(LAT_C);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q;
    logic [3:0]        sel_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;

    logic              accept;
    logic              enter_resp;
    logic              mem_wr;
    logic [3:0]        mem_sel;
    logic [ADDR_W-1:0] mem_idx;
    logic [31:0]       mem_wdata;

    // Byte offset and bits above the RAM size are deliberately dropped (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

    assign addr_ok = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign data_ok = (state_q == ST_RESP);
    assign accept  = req & addr_ok;

    // Next state and countdown; flags the edge that enters RESP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    if (LAT_C == 1) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM operands: with single-cycle latency the access happens on the accepting
    // edge itself, so the live inputs are used instead of the not-yet-loaded latch.
    always_comb begin
        mem_wr    = wr_q;
        mem_sel   = sel_q;
        mem_idx   = idx_q;
        mem_wdata = wdata_q;
        if (accept) begin
            mem_wr    = wr;
            mem_sel   = sel;
            mem_idx   = addr[ADDR_W+1:2];
            mem_wdata = wdata;
        end
    end

    // FSM state and countdown registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latch: captured on accept, held through WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= 1'b0;
            sel_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            wr_q    <= wr;
            sel_q   <= sel;
            idx_q   <= addr[ADDR_W+1:2];
            wdata_q <= wdata;
        end
    end

    byte_we_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .rst_ni  (rst),
        .rd_en_i (enter_resp & ~mem_wr),
        .we_i    ({4{enter_resp & mem_wr}} & mem_sel),
        .idx_i   (mem_idx),
        .wdata_i (mem_wdata),
        .rdata_o (rdata)
    );

endmodule

// File: tb/tb_sram_data_responder.sv
// Directed bench for sram_data_responder: four instances with LATENCY 2, 1, 3, 15.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_sram_data_responder;

    logic        clk;
    logic        rst_n;
    logic        req_s   [4];
    logic        wr_s    [4];
    logic [3:0]  sel_s   [4];
    logic [31:0] addr_s  [4];
    logic [31:0] wdata_s [4];
    logic        addr_ok_s [4];
    logic        data_ok_s [4];
    logic [31:0] rdata_s   [4];

    int n_chk;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sram_data_responder #(
            .ADDR_W  (10),
            .LATENCY ((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 15)
        ) u_dut (
            .clk     (clk),
            .rst     (rst_n),
            .req     (req_s[g]),
            .wr      (wr_s[g]),
            .sel     (sel_s[g]),
            .addr    (addr_s[g]),
            .wdata   (wdata_s[g]),
            .addr_ok (addr_ok_s[g]),
            .data_ok (data_ok_s[g]),
            .rdata   (rdata_s[g])
        );
    end

    // One request on instance k; reports what was observed, compares nothing.
    task automatic xact(input int k, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d, input logic toggle,
                        output logic acc_ok, output int lat, output logic [31:0] rd,
                        output int aok_wait, output logic dok_after);
        bit done;
        done     = 1'b0;
        lat      = 0;
        aok_wait = 0;
        rd       = 32'hx;
        @(negedge clk);
        req_s[k] = 1'b1; wr_s[k] = w; sel_s[k] = s; addr_s[k] = a; wdata_s[k] = d;
        acc_ok = addr_ok_s[k];
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (data_ok_s[k]) begin
                done = 1'b1;
                rd = rdata_s[k];
                req_s[k] = 1'b0;
            end else begin
                if (addr_ok_s[k]) aok_wait++;
                req_s[k] = toggle ? ~req_s[k] : 1'b0;
            end
        end
        req_s[k] = 1'b0;
        @(negedge clk);
        dok_after = data_ok_s[k];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (addr_ok_s[0] !== 1'b1) $display("FAIL reset_addr_ok got=%b exp=1", addr_ok_s[0]); else n_pass++;
        n_chk++; if (data_ok_s[0] !== 1'b0) $display("FAIL reset_data_ok got=%b exp=0", data_ok_s[0]); else n_pass++;
        n_chk++; if (rdata_s[0] !== 32'd0) $display("FAIL reset_rdata got=%h exp=0", rdata_s[0]); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic acc; int lat; logic [31:0] rd; int aw; logic da;
        xact(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, acc, lat, rd, aw, da);
        n_chk++; if (lat !== 2) $display("FAIL basic_wr_lat got=%0d exp=2", lat); else n_pass++;
        xact(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, acc, lat, rd, aw, da);
        n_chk++; if (acc !== 1'b1) $display("FAIL basic_rd_addr_ok got=%b exp=1", acc); else n_pass++;
        n_chk++; if (lat !== 2) $display("FAIL basic_rd_lat got=%0d exp=2", lat); else n_pass++;
        n_chk++; if (rd !== 32'hDEADBEEF) $display("FAIL basic_rd_data got=%h exp=deadbeef", rd); else n_pass++;
        n_chk++; if (da !== 1'b0) $display("FAIL basic_pulse_width got=%b exp=0", da); else n_pass++;
        n_chk++; if (aw !== 0) $display("FAIL basic_addr_ok_in_wait got=%0d exp=0", aw); else n_pass++;
    endtask

    task automatic test_byte_lanes();
        logic acc; int lat; logic [31:0] rd; int aw; logic da;
        xact(0, 1'b1, 4'hF, 32'h40, 32'h11223344, 1'b0, acc, lat, rd, aw, da);
        xact(0, 1'b1, 4'b0010, 32'h40, 32'h0000AA00, 1'b0, acc, lat, rd, aw, da);
        xact(0, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0, acc, lat, rd, aw, da);
        n_chk++; if (rd !== 32'h1122AA44) $display("FAIL lanes_merge got=%h exp=1122aa44", rd); else n_pass++;
        xact(0, 1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, 1'b0, acc, lat, rd, aw, da);
        n_chk++; if (lat !== 2) $display("FAIL lanes_sel0_data_ok lat got=%0d exp=2", lat); else n_pass++;
        xact(0, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0, acc, lat, rd, aw, da);
        n_chk++; if (rd !== 32'h1122AA44) $display("FAIL lanes_sel0_noop got=%h exp=1122aa44", rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic        op_w [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] op_a [4] = '{32'h100, 32'h100, 32'h104, 32'h104};
        logic [31:0] op_d [4] = '{32'h5, 32'h0, 32'h7, 32'h0};
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_chk++; if (data_ok_s[1] !== 1'b1) $display("FAIL b2b_data_ok[%0d] got=%b exp=1", i, data_ok_s[1]); else n_pass++;
            end
            if (i == 2) begin
                n_chk++; if (rdata_s[1] !== 32'h5) $display("FAIL b2b_rd0 got=%h exp=5", rdata_s[1]); else n_pass++;
            end
            if (i == 3) begin
                n_chk++; if (rdata_s[1] !== 32'h5) $display("FAIL b2b_hold_on_wr got=%h exp=5", rdata_s[1]); else n_pass++;
            end
            if (i == 4) begin
                n_chk++; if (rdata_s[1] !== 32'h7) $display("FAIL b2b_rd1 got=%h exp=7", rdata_s[1]); else n_pass++;
            end
            if (i < 4) begin
                n_chk++; if (addr_ok_s[1] !== 1'b1) $display("FAIL b2b_addr_ok[%0d] got=%b exp=1", i, addr_ok_s[1]); else n_pass++;
                req_s[1] = 1'b1; wr_s[1] = op_w[i]; sel_s[1] = 4'hF; addr_s[1] = op_a[i]; wdata_s[1] = op_d[i];
            end else begin
                req_s[1] = 1'b0;
            end
        end
        @(negedge clk);
        n_chk++; if (data_ok_s[1] !== 1'b0) $display("FAIL b2b_idle_after got=%b exp=0", data_ok_s[1]); else n_pass++;
    endtask

    task automatic test_latency_sweep();
        logic acc; int lat; logic [31:0] rd; int aw; logic da; int extra; int exp_lat;
        logic [31:0] val;
        for (int k = 1; k < 4; k++) begin
            exp_lat = (k == 1) ? 1 : (k == 2) ? 3 : 15;
            val = 32'hA5000000 + 32'(k);
            xact(k, 1'b1, 4'hF, 32'h200, val, 1'b1, acc, lat, rd, aw, da);
            n_chk++; if (acc !== 1'b1) $display("FAIL sweep_acc[L%0d] got=%b exp=1", exp_lat, acc); else n_pass++;
            n_chk++; if (lat !== exp_lat) $display("FAIL sweep_wr_lat[L%0d] got=%0d exp=%0d", exp_lat, lat, exp_lat); else n_pass++;
            n_chk++; if (aw !== 0) $display("FAIL sweep_addr_ok_wait[L%0d] got=%0d exp=0", exp_lat, aw); else n_pass++;
            extra = 0;
            repeat (20) begin
                @(negedge clk);
                if (data_ok_s[k]) extra++;
            end
            n_chk++; if (extra !== 0 || da !== 1'b0) $display("FAIL sweep_extra_accept[L%0d] got=%0d/%b exp=0/0", exp_lat, extra, da); else n_pass++;
            xact(k, 1'b0, 4'hF, 32'h200, 32'h0, 1'b1, acc, lat, rd, aw, da);
            n_chk++; if (lat !== exp_lat) $display("FAIL sweep_rd_lat[L%0d] got=%0d exp=%0d", exp_lat, lat, exp_lat); else n_pass++;
            n_chk++; if (rd !== val) $display("FAIL sweep_rd_data[L%0d] got=%h exp=%h", exp_lat, rd, val); else n_pass++;
        end
    endtask

    task automatic test_alias();
        logic acc; int lat; logic [31:0] rd; int aw; logic da;
        xact(0, 1'b1, 4'hF, 32'h0000_0004, 32'h12345678, 1'b0, acc, lat, rd, aw, da);
        xact(0, 1'b0, 4'hF, 32'h0000_1007, 32'h0, 1'b0, acc, lat, rd, aw, da);
        n_chk++; if (rd !== 32'h12345678) $display("FAIL alias_rd got=%h exp=12345678", rd); else n_pass++;
    endtask

    task automatic test_reset_midop();
        logic acc; int lat; logic [31:0] rd; int aw; logic da; int pulses;
        xact(3, 1'b1, 4'hF, 32'h300, 32'hCAFEF00D, 1'b0, acc, lat, rd, aw, da);
        @(negedge clk);
        req_s[3] = 1'b1; wr_s[3] = 1'b0; sel_s[3] = 4'hF; addr_s[3] = 32'h300;
        @(negedge clk);
        req_s[3] = 1'b0;
        @(negedge clk);
        n_chk++; if (addr_ok_s[3] !== 1'b0) $display("FAIL midop_in_wait addr_ok got=%b exp=0", addr_ok_s[3]); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++; if (addr_ok_s[3] !== 1'b1) $display("FAIL midop_async_addr_ok got=%b exp=1", addr_ok_s[3]); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (data_ok_s[3]) pulses++;
        end
        n_chk++; if (pulses !== 0) $display("FAIL midop_dropped data_ok pulses got=%0d exp=0", pulses); else n_pass++;
        n_chk++; if (addr_ok_s[3] !== 1'b1) $display("FAIL midop_idle_addr_ok got=%b exp=1", addr_ok_s[3]); else n_pass++;
        n_chk++; if (rdata_s[3] !== 32'd0) $display("FAIL midop_rdata_cleared got=%h exp=0", rdata_s[3]); else n_pass++;
        xact(3, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0, acc, lat, rd, aw, da);
        n_chk++; if (lat !== 15) $display("FAIL midop_reread_lat got=%0d exp=15", lat); else n_pass++;
        n_chk++; if (rd !== 32'hCAFEF00D) $display("FAIL midop_ram_kept got=%h exp=cafef00d", rd); else n_pass++;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_s[i] = 1'b0; wr_s[i] = 1'b0; sel_s[i] = 4'h0;
            addr_s[i] = 32'h0; wdata_s[i] = 32'h0;
        end
        test_reset();
        test_basic();
        test_byte_lanes();
        test_back_to_back();
        test_latency_sweep();
        test_alias();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
